id_ex_lanes: RTL and testbench
==============================

# id_ex_lanes

Parametrised, N-lane decode-to-execute pipeline register with a valid/ready handshake, a one-bundle skid buffer, and age-ordered partial flush. It sits between the issue/decode stage and the execute stage. It replaces fixed two-lane enable/clear registers with a registered-ready stage. A flush on lane i kills that lane and every younger lane, and the stage drains without combinational ready paths.

## Interface
- LANES, 2, number of issue lanes; lane 0 is oldest, higher index is younger
- WIDTH, 32, payload bits per lane; the opaque packed decode bundle
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  LANES  per-lane valid of the incoming bundle; must be contiguous from lane 0
- in_data  in  LANES*WIDTH  incoming payload; lane k occupies bits [k*WIDTH +: WIDTH]
- in_ready  out  1  stage can accept a bundle; registered
- out_valid  out  LANES  per-lane valid of the bundle presented to execute
- out_data  out  LANES*WIDTH  presented payload; lane layout as in_data
- out_ready  in  1  execute accepts the presented bundle
- flush  in  LANES  flush[i] kills lane i and all younger lanes; flush[0] empties the stage
- occupancy  out  2  number of bundles held: 0, 1 or 2

## Operation
- Storage: main register M (feeds out_*) and skid register S, each LANES valid bits plus payload.
- Bundles move as a whole. Lanes never reorder or compact.
- in_fire = in_ready & |in_valid. out_fire = out_ready & |out_valid.
- States, derived from the valids:
  - EMPTY: M invalid, S invalid.
  - BUSY: M valid, S invalid.
  - FULL: M valid, S valid.
- Transitions with no flush asserted:
  - EMPTY, in_fire: M <= in, go to BUSY.
  - BUSY, in_fire and out_fire: M <= in, stay BUSY.
  - BUSY, out_fire only: go to EMPTY.
  - BUSY, in_fire only: S <= in, go to FULL.
  - FULL, out_fire: M <= S, go to BUSY. in_ready is 0 in FULL, so in_fire cannot occur.
- in_ready next = (next state != FULL).
- Flush, with k = lowest set index of flush; flush takes priority over every handshake in that cycle:
  - M lanes >= k are cleared: valid 0, payload 0.
  - M lanes < k are retained and not dequeued, even when out_ready = 1.
  - S is cleared entirely.
  - The incoming bundle is dropped, even though in_ready was 1.
  - Resulting state: BUSY if any M lane remains valid, else EMPTY. in_ready next = 1.
- Every invalid lane always carries zero payload, in both M and S.
- A non-contiguous in_valid is illegal. The block stores it unchanged. Verification treats it as a protocol assertion failure.

## Timing
- Reset (rst low, asynchronous):
  - out_valid = 0, out_data = 0, M and S cleared.
  - occupancy = 0, in_ready = 1.
  - State leaves reset on the first clk edge after rst rises.
- Latency: a bundle accepted at edge t appears on out_* after edge t (1 cycle).
- Throughput: one bundle per cycle while out_ready is held high.
- Backpressure: in_ready falls one cycle after the stage fills. S absorbs the bundle accepted in that cycle.
- in_ready, out_valid, out_data and occupancy are registered outputs. There is no combinational path from any input to any output.
- Reset mid-operation discards M and S immediately, with no handshake.

## Test plan
- Reset then stream, LANES=2, WIDTH=32, out_ready=1:
  - Stimulus: bundles {A0,A1}, {B0,B1}, {C0,_} on consecutive cycles.
  - Required response: out_* shows them one cycle later, back to back.
  - For C, out_valid = 2'b01 and lane 1 data = 0.
  - in_ready stays 1.
- Backpressure: out_ready = 0 while two bundles are sent.
  - Required response: occupancy goes 1 then 2, and in_ready = 0 after the second bundle.
  - Release out_ready: A, then B, then occupancy 0 and in_ready = 1.
- Partial flush in FULL:
  - Setup: M = {A0,A1}, S = {B0,B1}.
  - Stimulus: flush = 2'b10 with out_ready = 1.
  - Required response next cycle: out_valid = 2'b01, lane 0 = A0, lane 1 data = 0, S empty, occupancy 1, in_ready 1.
- Full flush with a concurrent input:
  - Stimulus: flush = 2'b01 while in_fire brings {D0,D1}.
  - Required response next cycle: out_valid = 0, out_data = 0, occupancy 0, and D is never observed.
- Asynchronous reset:
  - Stimulus: assert rst low mid-cycle while in FULL.
  - Required response: outputs clear before the next clk edge.
  - Repeat at LANES=4, WIDTH=64 with flush = 4'b0100: lanes 0 and 1 are kept, lanes 2 and 3 are zeroed.

Source files
------------

// File: rtl/id_ex_lanes.sv
// Decode-to-execute pipeline register for LANES issue lanes.
// It has a registered ready, a one-bundle skid buffer and an age-ordered partial flush.
// Lane 0 is the oldest lane. A flush on lane k kills lane k and every younger lane.
module id_ex_lanes #(
  parameter int unsigned LANES = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  input  logic [LANES-1:0]       flush,
  output logic [1:0]             occupancy
);

  localparam int unsigned DW = LANES * WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LANES-1:0] m_vld_q, m_vld_d;
  logic [LANES-1:0] s_vld_q, s_vld_d;
  logic [DW-1:0]    m_dat_q, m_dat_d;
  logic [DW-1:0]    s_dat_q, s_dat_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       occ_q, occ_d;

  logic             in_fire;
  logic             out_fire;
  logic             flush_any;
  logic             keep_run;
  logic [LANES-1:0] keep;
  logic [DW-1:0]    in_dat_m;
  logic [DW-1:0]    keep_dat;

  assign in_fire   = in_ready_q & (|in_valid);
  assign out_fire  = out_ready & (|m_vld_q);
  assign flush_any = |flush;

  // Zero the payload of invalid incoming lanes.
  // Keep only the M lanes that are older than the lowest flushed lane.
  always_comb begin
    keep     = '0;
    in_dat_m = '0;
    keep_dat = '0;
    keep_run = 1'b1;
    for (int unsigned k = 0; k < LANES; k++) begin
      keep_run = keep_run & ~flush[k];
      keep[k]  = keep_run;
      in_dat_m[k*WIDTH +: WIDTH] = in_valid[k] ? in_data[k*WIDTH +: WIDTH] : '0;
      keep_dat[k*WIDTH +: WIDTH] = keep_run ? m_dat_q[k*WIDTH +: WIDTH] : '0;
    end
  end

  // Next-state logic. A flush overrides every handshake in its cycle.
  always_comb begin
    state_d = state_q;
    m_vld_d = m_vld_q;
    m_dat_d = m_dat_q;
    s_vld_d = s_vld_q;
    s_dat_d = s_dat_q;

    if (flush_any) begin
      m_vld_d = m_vld_q & keep;
      m_dat_d = keep_dat;
      s_vld_d = '0;
      s_dat_d = '0;
      state_d = (|(m_vld_q & keep)) ? ST_BUSY : ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            m_vld_d = in_valid;
            m_dat_d = in_dat_m;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            m_vld_d = in_valid;
            m_dat_d = in_dat_m;
          end else if (out_fire) begin
            m_vld_d = '0;
            m_dat_d = '0;
            state_d = ST_EMPTY;
          end else if (in_fire) begin
            s_vld_d = in_valid;
            s_dat_d = in_dat_m;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            m_vld_d = s_vld_q;
            m_dat_d = s_dat_q;
            s_vld_d = '0;
            s_dat_d = '0;
            state_d = ST_BUSY;
          end
        end
        default: begin
          m_vld_d = '0;
          m_dat_d = '0;
          s_vld_d = '0;
          s_dat_d = '0;
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Compute the registered ready and the occupancy from the next state.
  always_comb begin
    in_ready_d = 1'b1;
    occ_d      = 2'd0;
    unique case (state_d)
      ST_BUSY: occ_d = 2'd1;
      ST_FULL: begin
        occ_d      = 2'd2;
        in_ready_d = 1'b0;
      end
      default: occ_d = 2'd0;
    endcase
  end

  // State and storage registers. Reset clears them asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      m_vld_q    <= '0;
      m_dat_q    <= '0;
      s_vld_q    <= '0;
      s_dat_q    <= '0;
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      m_vld_q    <= m_vld_d;
      m_dat_q    <= m_dat_d;
      s_vld_q    <= s_vld_d;
      s_dat_q    <= s_dat_d;
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_vld_q;
  assign out_data  = m_dat_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_id_ex_lanes.sv
// Directed bench for id_ex_lanes.
// Instance a is built with LANES=2 and WIDTH=32.
// Instance b is built with LANES=4 and WIDTH=64.
module tb_id_ex_lanes;

  logic clk;
  logic rst;

  logic [1:0]   a_in_valid;
  logic [63:0]  a_in_data;
  logic         a_in_ready;
  logic [1:0]   a_out_valid;
  logic [63:0]  a_out_data;
  logic         a_out_ready;
  logic [1:0]   a_flush;
  logic [1:0]   a_occ;

  logic [3:0]   b_in_valid;
  logic [255:0] b_in_data;
  logic         b_in_ready;
  logic [3:0]   b_out_valid;
  logic [255:0] b_out_data;
  logic         b_out_ready;
  logic [3:0]   b_flush;
  logic [1:0]   b_occ;

  int n_cmp;
  int n_mis;

  localparam logic [31:0] A0 = 32'hA000_00A0, A1 = 32'hA111_11A1;
  localparam logic [31:0] B0 = 32'hB000_00B0, B1 = 32'hB111_11B1;
  localparam logic [31:0] C0 = 32'hC000_00C0, JUNK = 32'hDEAD_BEEF;
  localparam logic [31:0] D0 = 32'hD000_00D0, D1 = 32'hD111_11D1;
  localparam logic [63:0] E0 = 64'hE000_0000_0000_00E0, E1 = 64'hE111_1111_1111_11E1;
  localparam logic [63:0] E2 = 64'hE222_2222_2222_22E2, E3 = 64'hE333_3333_3333_33E3;
  localparam logic [63:0] F0 = 64'hF000_0000_0000_00F0, F1 = 64'hF111_1111_1111_11F1;
  localparam logic [63:0] F2 = 64'hF222_2222_2222_22F2, F3 = 64'hF333_3333_3333_33F3;

  id_ex_lanes #(.LANES(2), .WIDTH(32)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_data   (a_in_data),
    .in_ready  (a_in_ready),
    .out_valid (a_out_valid),
    .out_data  (a_out_data),
    .out_ready (a_out_ready),
    .flush     (a_flush),
    .occupancy (a_occ)
  );

  id_ex_lanes #(.LANES(4), .WIDTH(64)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_data   (b_in_data),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_ready (b_out_ready),
    .flush     (b_flush),
    .occupancy (b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Non-contiguous lane valids are a protocol violation.
  always @(posedge clk) begin
    if (rst && ((a_in_valid & (a_in_valid + 2'd1)) != 2'd0))
      $error("protocol: non-contiguous a_in_valid %b", a_in_valid);
    if (rst && ((b_in_valid & (b_in_valid + 4'd1)) != 4'd0))
      $error("protocol: non-contiguous b_in_valid %b", b_in_valid);
  end

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] v, input logic [63:0] d);
    a_in_valid = v;
    a_in_data  = d;
  endtask

  task automatic check_a(input string tag, input logic [1:0] v, input logic [63:0] d,
                         input logic [1:0] occ, input logic rdy);
    check_eq({tag, ".valid"}, 256'(a_out_valid), 256'(v));
    check_eq({tag, ".data"},  256'(a_out_data),  256'(d));
    check_eq({tag, ".occ"},   256'(a_occ),       256'(occ));
    check_eq({tag, ".ready"}, 256'(a_in_ready),  256'(rdy));
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b0;
    a_in_valid = '0; a_in_data = '0; a_out_ready = 1'b0; a_flush = '0;
    b_in_valid = '0; b_in_data = '0; b_out_ready = 1'b0; b_flush = '0;

    // The stage is cleared while reset is held.
    step();
    step();
    check_a("reset", 2'b00, 64'h0, 2'd0, 1'b1);
    check_eq("reset.b_valid", 256'(b_out_valid), 256'(4'b0000));
    check_eq("reset.b_ready", 256'(b_in_ready), 256'(1'b1));
    @(negedge clk);
    rst = 1'b1;

    // Stream three bundles back to back with out_ready held high.
    a_out_ready = 1'b1;
    drive_a(2'b11, {A1, A0});
    step();
    check_a("stream.A", 2'b11, {A1, A0}, 2'd1, 1'b1);
    drive_a(2'b11, {B1, B0});
    step();
    check_a("stream.B", 2'b11, {B1, B0}, 2'd1, 1'b1);
    drive_a(2'b01, {JUNK, C0});
    step();
    check_a("stream.C", 2'b01, {32'h0, C0}, 2'd1, 1'b1);
    drive_a(2'b00, 64'h0);
    step();
    check_a("stream.drain", 2'b00, 64'h0, 2'd0, 1'b1);

    // Apply backpressure: the skid buffer fills and then ready falls.
    a_out_ready = 1'b0;
    drive_a(2'b11, {A1, A0});
    step();
    check_a("bp.one", 2'b11, {A1, A0}, 2'd1, 1'b1);
    drive_a(2'b11, {B1, B0});
    step();
    check_a("bp.two", 2'b11, {A1, A0}, 2'd2, 1'b0);
    drive_a(2'b00, 64'h0);
    a_out_ready = 1'b1;
    step();
    check_a("bp.relB", 2'b11, {B1, B0}, 2'd1, 1'b1);
    step();
    check_a("bp.empty", 2'b00, 64'h0, 2'd0, 1'b1);

    // Apply a partial flush of lane 1 while the stage is FULL.
    a_out_ready = 1'b0;
    drive_a(2'b11, {A1, A0});
    step();
    drive_a(2'b11, {B1, B0});
    step();
    check_a("pf.full", 2'b11, {A1, A0}, 2'd2, 1'b0);
    drive_a(2'b00, 64'h0);
    a_flush = 2'b10;
    a_out_ready = 1'b1;
    step();
    check_a("pf.kept", 2'b01, {32'h0, A0}, 2'd1, 1'b1);
    a_flush = 2'b00;
    step();
    check_a("pf.noskid", 2'b00, 64'h0, 2'd0, 1'b1);

    // Apply a full flush while an input bundle fires in the same cycle.
    a_out_ready = 1'b0;
    drive_a(2'b11, {A1, A0});
    step();
    drive_a(2'b11, {D1, D0});
    a_flush = 2'b01;
    a_out_ready = 1'b1;
    step();
    check_a("ff.clear", 2'b00, 64'h0, 2'd0, 1'b1);
    drive_a(2'b00, 64'h0);
    a_flush = 2'b00;
    step();
    check_a("ff.noD", 2'b00, 64'h0, 2'd0, 1'b1);

    // Assert reset mid-cycle while the stage is FULL.
    a_out_ready = 1'b0;
    drive_a(2'b11, {A1, A0});
    step();
    drive_a(2'b11, {B1, B0});
    step();
    check_a("ar.full", 2'b11, {A1, A0}, 2'd2, 1'b0);
    drive_a(2'b00, 64'h0);
    #2;
    rst = 1'b0;
    #1;
    check_a("ar.async", 2'b00, 64'h0, 2'd0, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // LANES=4: flush from lane 2 while FULL keeps lanes 0 and 1.
    b_out_ready = 1'b0;
    b_in_valid = 4'b1111;
    b_in_data = {E3, E2, E1, E0};
    step();
    check_eq("b.one.valid", 256'(b_out_valid), 256'(4'b1111));
    b_in_data = {F3, F2, F1, F0};
    step();
    check_eq("b.full.occ", 256'(b_occ), 256'(2'd2));
    check_eq("b.full.ready", 256'(b_in_ready), 256'(1'b0));
    b_in_valid = 4'b0000;
    b_in_data = '0;
    b_flush = 4'b0100;
    b_out_ready = 1'b1;
    step();
    check_eq("b.pf.valid", 256'(b_out_valid), 256'(4'b0011));
    check_eq("b.pf.data", b_out_data, {64'h0, 64'h0, E1, E0});
    check_eq("b.pf.occ", 256'(b_occ), 256'(2'd1));
    check_eq("b.pf.ready", 256'(b_in_ready), 256'(1'b1));
    b_flush = 4'b0000;
    step();
    check_eq("b.drain.valid", 256'(b_out_valid), 256'(4'b0000));
    check_eq("b.drain.occ", 256'(b_occ), 256'(2'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Watchdog that stops a run that never finishes.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
